// File: rtl/canvas_sampler_pkg.sv
// ============================================================================
// Module   : canvas_sampler_pkg
// Purpose  : Canvas geometry shared with the draw/erase datapath, plus the
//            sampler FSM state encodings.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package canvas_sampler_pkg;

  // Canvas placement and size in framebuffer coordinates
  localparam int unsigned CANVAS_X0_DEF = 89;
  localparam int unsigned CANVAS_Y0_DEF = 33;
  localparam int unsigned CANVAS_W      = 140;
  localparam int unsigned CANVAS_H      = 196;

  // Reduction cell and NN image size
  localparam int unsigned CELL_W_DEF    = 5;
  localparam int unsigned CELL_H_DEF    = 7;
  localparam int unsigned GRID_DEF      = 28;

  localparam logic [2:0]  BG_COLOUR_DEF = 3'b111;

  // Sampler FSM encoding
  localparam logic [1:0]  ST_IDLE  = 2'd0;
  localparam logic [1:0]  ST_SCAN  = 2'd1;
  localparam logic [1:0]  ST_DRAIN = 2'd2;

endpackage

`default_nettype wire

// File: rtl/canvas_sampler_addr_gen.sv
// ============================================================================
// Module   : canvas_addr_gen
// Purpose  : Walks the canvas one cell at a time (raster order inside a cell,
//            cells row-major) and produces framebuffer read addresses plus
//            first/last-of-cell flags aligned with the presented address.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module canvas_addr_gen #(
  parameter int unsigned CANVAS_X0 = 89,
  parameter int unsigned CANVAS_Y0 = 33,
  parameter int unsigned CELL_W    = 5,
  parameter int unsigned CELL_H    = 7,
  parameter int unsigned GRID      = 28
) (
  input  logic       clock,
  input  logic       count_reset,
  input  logic       load_i,
  input  logic       step_i,
  output logic [7:0] x_o,
  output logic [7:0] y_o,
  output logic       first_o,
  output logic       last_o,
  output logic       final_o
);

  localparam logic [2:0] SUB_X_MAX = 3'(CELL_W - 1);
  localparam logic [2:0] SUB_Y_MAX = 3'(CELL_H - 1);
  localparam logic [4:0] CELL_MAX  = 5'(GRID - 1);
  localparam logic [7:0] STEP_X    = 8'(CELL_W);
  localparam logic [7:0] STEP_Y    = 8'(CELL_H);
  localparam logic [7:0] ORG_X     = 8'(CANVAS_X0);
  localparam logic [7:0] ORG_Y     = 8'(CANVAS_Y0);

  logic [2:0] sub_x_q,  sub_x_d;
  logic [2:0] sub_y_q,  sub_y_d;
  logic [4:0] cell_x_q, cell_x_d;
  logic [4:0] cell_y_q, cell_y_d;
  logic [7:0] base_x_q, base_x_d;
  logic [7:0] base_y_q, base_y_d;
  logic [7:0] x_q, x_d;
  logic [7:0] y_q, y_d;

  // Nested counter advance; cell bases are running sums so no multiply is needed
  always_comb begin
    sub_x_d  = sub_x_q;
    sub_y_d  = sub_y_q;
    cell_x_d = cell_x_q;
    cell_y_d = cell_y_q;
    base_x_d = base_x_q;
    base_y_d = base_y_q;
    if (load_i) begin
      sub_x_d  = '0;
      sub_y_d  = '0;
      cell_x_d = '0;
      cell_y_d = '0;
      base_x_d = '0;
      base_y_d = '0;
    end else if (step_i) begin
      if (sub_x_q == SUB_X_MAX) begin
        sub_x_d = '0;
        if (sub_y_q == SUB_Y_MAX) begin
          sub_y_d = '0;
          if (cell_x_q == CELL_MAX) begin
            cell_x_d = '0;
            base_x_d = '0;
            cell_y_d = cell_y_q + 5'd1;
            base_y_d = base_y_q + STEP_Y;
          end else begin
            cell_x_d = cell_x_q + 5'd1;
            base_x_d = base_x_q + STEP_X;
          end
        end else begin
          sub_y_d = sub_y_q + 3'd1;
        end
      end else begin
        sub_x_d = sub_x_q + 3'd1;
      end
    end
    x_d = ORG_X + base_x_d + {5'd0, sub_x_d};
    y_d = ORG_Y + base_y_d + {5'd0, sub_y_d};
  end

  // Counter state; the address registers only move when a new address is issued
  always_ff @(posedge clock or negedge count_reset) begin
    if (!count_reset) begin
      sub_x_q  <= '0;
      sub_y_q  <= '0;
      cell_x_q <= '0;
      cell_y_q <= '0;
      base_x_q <= '0;
      base_y_q <= '0;
      x_q      <= '0;
      y_q      <= '0;
    end else begin
      sub_x_q  <= sub_x_d;
      sub_y_q  <= sub_y_d;
      cell_x_q <= cell_x_d;
      cell_y_q <= cell_y_d;
      base_x_q <= base_x_d;
      base_y_q <= base_y_d;
      if (load_i || step_i) begin
        x_q <= x_d;
        y_q <= y_d;
      end
    end
  end

  assign x_o     = x_q;
  assign y_o     = y_q;
  assign first_o = (sub_x_q == 3'd0) && (sub_y_q == 3'd0);
  assign last_o  = (sub_x_q == SUB_X_MAX) && (sub_y_q == SUB_Y_MAX);
  assign final_o = last_o && (cell_x_q == CELL_MAX) && (cell_y_q == CELL_MAX);

endmodule

`default_nettype wire

// File: rtl/canvas_sampler.sv
// ============================================================================
// Module   : canvas_sampler
// Purpose  : Reads the drawing canvas back from the framebuffer and reduces it
//            to a 28x28 ink-count image, one pixel per 5x7 cell.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module canvas_sampler
  import canvas_sampler_pkg::*;
#(
  parameter int unsigned CANVAS_X0 = CANVAS_X0_DEF,
  parameter int unsigned CANVAS_Y0 = CANVAS_Y0_DEF,
  parameter int unsigned CELL_W    = CELL_W_DEF,
  parameter int unsigned CELL_H    = CELL_H_DEF,
  parameter int unsigned GRID      = GRID_DEF,
  parameter logic [2:0]  BG_COLOUR = BG_COLOUR_DEF
) (
  input  logic       clock,
  input  logic       count_reset,
  input  logic       start,
  output logic       busy,
  output logic       rd_en,
  output logic [7:0] x_out,
  output logic [7:0] y_out,
  input  logic [2:0] pix_in,
  output logic       pixel_valid,
  output logic [9:0] pixel_idx,
  output logic [5:0] pixel_data,
  output logic       done
);

  logic [1:0] state_q, state_d;
  logic       addr_load, addr_step;
  logic       addr_first, addr_last, addr_final;

  // Flags delayed one cycle so they line up with the returning read data
  logic       rd_vld_q;
  logic       first_dly_q, last_dly_q, final_dly_q;

  logic [5:0] acc_q;
  logic [9:0] idx_cnt_q;
  logic       pixel_valid_q, done_q;
  logic [9:0] pixel_idx_q;
  logic [5:0] pixel_data_q;

  logic       ink;
  logic [5:0] acc_sum;
  logic       emit;

  canvas_addr_gen #(
    .CANVAS_X0 (CANVAS_X0),
    .CANVAS_Y0 (CANVAS_Y0),
    .CELL_W    (CELL_W),
    .CELL_H    (CELL_H),
    .GRID      (GRID)
  ) u_addr_gen (
    .clock       (clock),
    .count_reset (count_reset),
    .load_i      (addr_load),
    .step_i      (addr_step),
    .x_o         (x_out),
    .y_o         (y_out),
    .first_o     (addr_first),
    .last_o      (addr_last),
    .final_o     (addr_final)
  );

  // Scan control: start is only honoured from IDLE; the address generator
  // freezes on the final address so x_out/y_out hold after the scan
  always_comb begin
    state_d   = state_q;
    addr_load = 1'b0;
    addr_step = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_SCAN;
          addr_load = 1'b1;
        end
      end
      ST_SCAN: begin
        if (addr_final) state_d = ST_DRAIN;
        else            addr_step = 1'b1;
      end
      ST_DRAIN: begin
        if (done_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clock or negedge count_reset) begin
    if (!count_reset) state_q <= ST_IDLE;
    else              state_q <= state_d;
  end

  assign busy  = (state_q != ST_IDLE);
  assign rd_en = (state_q == ST_SCAN);

  // The first sample of a cell restarts the count instead of adding to it
  assign ink     = (pix_in != BG_COLOUR);
  assign acc_sum = (first_dly_q ? 6'd0 : acc_q) + {5'd0, ink};
  assign emit    = rd_vld_q && last_dly_q;

  // Read-latency alignment, accumulation and result registers
  always_ff @(posedge clock or negedge count_reset) begin
    if (!count_reset) begin
      rd_vld_q      <= 1'b0;
      first_dly_q   <= 1'b0;
      last_dly_q    <= 1'b0;
      final_dly_q   <= 1'b0;
      acc_q         <= '0;
      idx_cnt_q     <= '0;
      pixel_valid_q <= 1'b0;
      pixel_idx_q   <= '0;
      pixel_data_q  <= '0;
      done_q        <= 1'b0;
    end else begin
      rd_vld_q      <= rd_en;
      first_dly_q   <= addr_first;
      last_dly_q    <= addr_last;
      final_dly_q   <= addr_final;
      pixel_valid_q <= emit;
      done_q        <= emit && final_dly_q;
      if (rd_vld_q) acc_q <= acc_sum;
      if (addr_load) begin
        idx_cnt_q <= '0;
      end else if (emit) begin
        pixel_data_q <= acc_sum;
        pixel_idx_q  <= idx_cnt_q;
        idx_cnt_q    <= idx_cnt_q + 10'd1;
      end
    end
  end

  assign pixel_valid = pixel_valid_q;
  assign pixel_idx   = pixel_idx_q;
  assign pixel_data  = pixel_data_q;
  assign done        = done_q;

endmodule

`default_nettype wire
